// File: rtl/booth_prod_accum.sv
// rtl/booth_prod_accum.sv - saturating signed MAC back end for the Booth multiplier
// Accumulates products per frame; presents sum, term count and overflow on valid/ready.
module booth_prod_accum #(
  parameter int SIZE  = 8,
  parameter int ACC_W = 24,
  parameter int CNT_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [2*SIZE-1:0]  prod,
  input  logic               prod_valid,
  input  logic               prod_last,
  output logic               prod_ready,
  input  logic               clear,
  output logic [ACC_W-1:0]   acc_out,
  output logic [CNT_W-1:0]   acc_cnt,
  output logic               acc_ovf,
  output logic               acc_valid,
  input  logic               acc_ready
);

  typedef enum logic {ACCUM = 1'b0, OUT = 1'b1} state_t;

  state_t             r_state;
  logic [ACC_W-1:0]   r_acc;
  logic [CNT_W-1:0]   r_cnt;
  logic               r_ovf;
  logic [ACC_W-1:0]   r_acc_out;
  logic [CNT_W-1:0]   r_acc_cnt;
  logic               r_acc_ovf;

  logic [ACC_W:0]     w_ext;
  logic [ACC_W:0]     w_sum;
  logic [ACC_W-1:0]   w_sat;
  logic               w_clamp;
  logic [CNT_W-1:0]   w_cnt_nxt;

  // One guard bit above the accumulator is enough: a 2*SIZE-bit term can at
  // most double the accumulator magnitude, so the sum itself never wraps.
  assign w_ext   = {{(ACC_W+1-2*SIZE){prod[2*SIZE-1]}}, prod};
  assign w_sum   = {r_acc[ACC_W-1], r_acc} + w_ext;
  assign w_clamp = w_sum[ACC_W] ^ w_sum[ACC_W-1];

  always_comb begin
    w_sat = w_sum[ACC_W-1:0];
    if (w_clamp) begin
      w_sat = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  assign w_cnt_nxt = (&r_cnt) ? r_cnt : r_cnt + 1'b1;

  assign prod_ready = rst_n & (r_state == ACCUM);
  assign acc_valid  = (r_state == OUT);
  assign acc_out    = r_acc_out;
  assign acc_cnt    = r_acc_cnt;
  assign acc_ovf    = r_acc_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ACCUM;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_acc_out <= '0;
      r_acc_cnt <= '0;
      r_acc_ovf <= 1'b0;
    end else if (clear) begin
      r_state <= ACCUM;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_ovf   <= 1'b0;
    end else begin
      case (r_state)
        ACCUM: begin
          if (prod_valid) begin
            if (prod_last) begin
              r_acc_out <= w_sat;
              r_acc_cnt <= w_cnt_nxt;
              r_acc_ovf <= r_ovf | w_clamp;
              r_acc     <= '0;
              r_cnt     <= '0;
              r_ovf     <= 1'b0;
              r_state   <= OUT;
            end else begin
              r_acc <= w_sat;
              r_cnt <= w_cnt_nxt;
              r_ovf <= r_ovf | w_clamp;
            end
          end
        end
        OUT: begin
          // No bypass: a product offered during the release cycle waits.
          if (acc_ready) r_state <= ACCUM;
        end
        default: r_state <= ACCUM;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_prod_accum.sv
// tb/tb_booth_prod_accum.sv - scoreboard bench for booth_prod_accum
module tb_booth_prod_accum;
  localparam int SIZE  = 8;
  localparam int ACC_W = 17;
  localparam int CNT_W = 8;
  localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W-1));
  localparam longint CMAX = (64'sd1 <<< CNT_W) - 1;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [2*SIZE-1:0]  prod = '0;
  logic               prod_valid = 1'b0;
  logic               prod_last = 1'b0;
  logic               prod_ready;
  logic               clear = 1'b0;
  logic [ACC_W-1:0]   acc_out;
  logic [CNT_W-1:0]   acc_cnt;
  logic               acc_ovf;
  logic               acc_valid;
  logic               acc_ready = 1'b0;

  booth_prod_accum #(.SIZE(SIZE), .ACC_W(ACC_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .prod(prod), .prod_valid(prod_valid),
    .prod_last(prod_last), .prod_ready(prod_ready), .clear(clear),
    .acc_out(acc_out), .acc_cnt(acc_cnt), .acc_ovf(acc_ovf),
    .acc_valid(acc_valid), .acc_ready(acc_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint acc;
    longint cnt;
    bit     ovf;
  } exp_t;

  exp_t   sb[$];
  int     n_cmp = 0;
  int     n_bad = 0;
  longint m_acc = 0;
  longint m_cnt = 0;
  bit     m_ovf = 1'b0;

  task automatic check(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic longint sx(input logic [ACC_W-1:0] v);
    return longint'($signed(v));
  endfunction

  task automatic model_reset();
    m_acc = 0;
    m_cnt = 0;
    m_ovf = 1'b0;
  endtask

  // Drives one term starting at posedge+1 and returns at the next posedge+1.
  task automatic send(input longint p, input bit last);
    exp_t e;
    prod       = p[2*SIZE-1:0];
    prod_valid = 1'b1;
    prod_last  = last;
    @(negedge clk);
    check("prod_ready_accum", longint'(prod_ready), 1);
    @(posedge clk);
    m_acc = m_acc + p;
    if (m_acc > MAXV) begin m_acc = MAXV; m_ovf = 1'b1; end
    if (m_acc < MINV) begin m_acc = MINV; m_ovf = 1'b1; end
    m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
    if (last) begin
      e.acc = m_acc; e.cnt = m_cnt; e.ovf = m_ovf;
      sb.push_back(e);
      model_reset();
    end
    #1;
    prod_valid = 1'b0;
    prod_last  = 1'b0;
  endtask

  task automatic drain();
    bit seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (acc_valid) begin seen = 1'b1; break; end
      @(posedge clk); #1;
    end
    if (!seen) check("drain_timeout", 0, 1);
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0;
    check("valid_after_drain", longint'(acc_valid), 0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst_n && acc_valid && acc_ready && !clear) begin
      if (sb.size() == 0) begin
        check("sb_unexpected_result", 1, 0);
      end else begin
        e = sb.pop_front();
        check("acc_out", sx(acc_out), e.acc);
        check("acc_cnt", longint'(acc_cnt), e.cnt);
        check("acc_ovf", longint'(acc_ovf), longint'(e.ovf));
      end
    end
  end

  initial begin
    #2;
    check("rst_prod_ready", longint'(prod_ready), 0);
    check("rst_acc_valid", longint'(acc_valid), 0);
    check("rst_acc_out", sx(acc_out), 0);
    check("rst_acc_cnt", longint'(acc_cnt), 0);
    check("rst_acc_ovf", longint'(acc_ovf), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame plus backpressure; an offered product in OUT must be ignored.
    send(6, 0);
    send(-20, 0);
    check("valid_before_last", longint'(acc_valid), 0);
    send(100, 1);
    check("latency_valid", longint'(acc_valid), 1);
    prod = 16'd55; prod_valid = 1'b1; prod_last = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_valid", longint'(acc_valid), 1);
      check("bp_prod_ready", longint'(prod_ready), 0);
      check("bp_acc_out", sx(acc_out), 86);
      check("bp_acc_cnt", longint'(acc_cnt), 3);
    end
    @(posedge clk); #1;
    acc_ready = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0; prod_valid = 1'b0; prod_last = 1'b0;
    check("release_valid", longint'(acc_valid), 0);
    check("release_prod_ready", longint'(prod_ready), 1);

    // Positive saturation, sticky flag, continue from clamped value.
    send(32767, 0); send(32767, 0); send(32767, 0); send(-1, 1);
    drain();
    // Negative saturation.
    for (int i = 0; i < 5; i++) send(-16384, i == 4);
    drain();

    // clear mid-frame drops the frame and the concurrent product.
    send(10, 0); send(20, 0);
    prod = 16'd99; prod_valid = 1'b1; prod_last = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0; prod_valid = 1'b0; prod_last = 1'b0;
    model_reset();
    send(7, 1);
    drain();

    // clear in OUT beats the handshake; result registers keep their values.
    send(5, 1);
    acc_ready = 1'b1; clear = 1'b1;
    @(posedge clk); #1;
    acc_ready = 1'b0; clear = 1'b0;
    check("clr_out_valid", longint'(acc_valid), 0);
    check("clr_out_hold_acc", sx(acc_out), 5);
    check("clr_out_hold_cnt", longint'(acc_cnt), 1);
    if (sb.size() > 0) void'(sb.pop_front());

    // Most negative product as a one-term frame.
    send(-32768, 1);
    drain();

    // Term counter saturates instead of wrapping.
    for (int i = 0; i < 260; i++) send(0, i == 259);
    drain();

    // Asynchronous reset mid-frame, between edges.
    send(3, 0); send(4, 0);
    #3 rst_n = 1'b0;
    #1;
    check("arst_mid_prod_ready", longint'(prod_ready), 0);
    check("arst_mid_valid", longint'(acc_valid), 0);
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    send(9, 1);
    #3 rst_n = 1'b0;
    #1;
    check("arst_out_valid", longint'(acc_valid), 0);
    check("arst_out_prod_ready", longint'(prod_ready), 0);
    check("arst_out_acc", sx(acc_out), 0);
    sb.delete();
    model_reset();
    @(posedge clk); #1 rst_n = 1'b1;
    send(1, 1);
    drain();

    repeat (2) @(posedge clk);
    check("sb_leftover", longint'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

endmodule
